// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin shares one 8N1 UART transmit line among NUM_REQ byte sources.
// Define UART_TX_ARBITER_PARITY_EN to insert an even-parity bit after data bit 7.
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int BAUD_DIV = 434,
  parameter int CNT_W    = 9
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   REQ,
  input  logic [NUM_REQ*8-1:0] DIN,
  output logic [NUM_REQ-1:0]   ACK,
  output logic [NUM_REQ-1:0]   GRANT,
  output logic                 DONE,
  output logic                 BUSY,
  output logic                 TXD
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(BAUD_DIV - 1);
`ifdef UART_TX_ARBITER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t             r_state, w_state;
  logic [PW-1:0]      r_ptr, w_ptr, w_win, w_j;
  logic [7:0]         r_shift, w_shift;
  logic [2:0]         r_idx, w_idx;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [NUM_REQ-1:0] r_grant, w_grant, r_ack, w_ack, w_oh;
  logic               r_txd, w_txd, w_tick;
  logic [7:0]         w_din [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_din
    assign w_din[g] = DIN[8*g +: 8];
  end
  // Scanning downward and overwriting leaves the first requester at or after the pointer.
  always_comb begin
    w_win = '0;
    w_j   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = PW'((int'(r_ptr) + k) % NUM_REQ);
      if (REQ[w_j]) w_win = w_j;
    end
  end
  assign w_oh   = NUM_REQ'(1) << w_win;
  assign w_tick = r_cnt == '0;
  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_shift = r_shift;
    w_idx   = r_idx;
    w_cnt   = r_state == IDLE ? r_cnt : r_cnt - CNT_W'(1);
    w_grant = r_grant;
    w_ack   = '0;
    w_txd   = r_txd;
    case (r_state)
      IDLE: if (|REQ) begin
        w_state = START;
        w_shift = w_din[w_win];
        w_grant = w_oh;
        w_ack   = w_oh;
        w_txd   = 1'b0;
        w_ptr   = PW'((int'(w_win) + 1) % NUM_REQ);
        w_cnt   = LOAD;
      end
      START: if (w_tick) begin
        w_state = DATA;
        w_idx   = '0;
        w_txd   = r_shift[0];
        w_cnt   = LOAD;
      end
      DATA: if (w_tick) begin
        w_cnt = LOAD;
        if (r_idx != 3'd7) begin
          w_idx = r_idx + 3'd1;
          w_txd = r_shift[r_idx + 3'd1];
        end else begin
`ifdef UART_TX_ARBITER_PARITY_EN
          w_state = PARITY;
          w_txd   = ^r_shift;
`else
          w_state = STOP;
          w_txd   = 1'b1;
`endif
        end
      end
`ifdef UART_TX_ARBITER_PARITY_EN
      PARITY: if (w_tick) begin
        w_state = STOP;
        w_txd   = 1'b1;
        w_cnt   = LOAD;
      end
`endif
      STOP: if (w_tick) begin
        w_state = IDLE;
        w_grant = '0;
        w_cnt   = '0;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_ack   <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_shift <= w_shift;
      r_idx   <= w_idx;
      r_cnt   <= w_cnt;
      r_grant <= w_grant;
      r_ack   <= w_ack;
      r_txd   <= w_txd;
    end
  end
  assign ACK   = r_ack;
  assign GRANT = r_grant;
  assign DONE  = r_state == STOP && w_tick;
  assign BUSY  = r_state != IDLE;
  assign TXD   = r_txd;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench decoding TXD frames at BAUD_DIV=4.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int BD = 4;
`ifdef UART_TX_ARBITER_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   REQ;
  logic [N*8-1:0] DIN;
  logic [N-1:0]   ACK, GRANT;
  logic           DONE, BUSY, TXD;
  typedef struct packed {logic [3:0] g; logic [7:0] b;} exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  uart_tx_arbiter #(.NUM_REQ(N), .BAUD_DIV(BD), .CNT_W(9)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DIN(DIN), .ACK(ACK),
    .GRANT(GRANT), .DONE(DONE), .BUSY(BUSY), .TXD(TXD)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [3:0] g, input logic [7:0] b);
    q.push_back({g, b});
  endtask
  task automatic wait_ack();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (ACK == '0 && n < 200);
    chk("ack_seen", 32'(ACK != '0), 32'd1);
  endtask
  task automatic idle_chk(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk(tag, 32'({TXD, BUSY, GRANT, ACK, DONE}), 32'h400);
    end
  endtask
  task automatic check_frame(input bit last, input bit scr);
    exp_t e;
    logic [NB-1:0] bits;
    e = q.pop_front();
    wait_ack();
    if (last) REQ = '0;
    if (scr) DIN = ~DIN;
    chk("ack", 32'(ACK), 32'(e.g));
    chk("grant", 32'(GRANT), 32'(e.g));
    chk("busy", 32'(BUSY), 32'd1);
    chk("txd_start", 32'(TXD), 32'd0);
    for (int b = 0; b < NB; b++) begin
      if (b == 0) @(negedge CLK);
      else repeat (BD) @(negedge CLK);
      bits[b] = TXD;
      if (b == 0) chk("ack_pulse", 32'(ACK), 32'd0);
    end
    chk("grant_hold", 32'(GRANT), 32'(e.g));
    @(negedge CLK);
    chk("done_early", 32'(DONE), 32'd0);
    @(negedge CLK);
    chk("done", 32'(DONE), 32'd1);
    @(negedge CLK);
    chk("end_idle", 32'({BUSY, GRANT, DONE}), 32'd0);
    chk("start_bit", 32'(bits[0]), 32'd0);
    chk("byte", 32'(bits[8:1]), 32'(e.b));
    chk("stop_bit", 32'(bits[NB-1]), 32'd1);
`ifdef UART_TX_ARBITER_PARITY_EN
    chk("parity", 32'(bits[9]), 32'(^e.b));
`endif
  endtask
  initial begin
    RST = 1'b1;
    REQ = '0;
    DIN = '0;
    repeat (2) @(negedge CLK);
    chk("reset", 32'({TXD, BUSY, GRANT, ACK, DONE}), 32'h400);
    RST = 1'b0;
    idle_chk(50, "idle");
    DIN[7:0] = 8'hA5;
    REQ = 4'b0001;
    push(4'b0001, 8'hA5);
    check_frame(1'b1, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    DIN = 32'h44332211;
    REQ = 4'b1111;
    push(4'b0001, 8'h11);
    push(4'b0010, 8'h22);
    push(4'b0100, 8'h33);
    push(4'b1000, 8'h44);
    push(4'b0001, 8'h11);
    for (int i = 0; i < 4; i++) check_frame(1'b0, 1'b0);
    check_frame(1'b1, 1'b0);
    REQ = 4'b0100;
    push(4'b0100, 8'h33);
    check_frame(1'b1, 1'b0);
    REQ = 4'b0101;
    push(4'b0001, 8'h11);
    push(4'b0100, 8'h33);
    check_frame(1'b0, 1'b0);
    check_frame(1'b1, 1'b0);
    DIN = 32'h00005A00;
    REQ = 4'b0010;
    wait_ack();
    REQ = '0;
    repeat (16) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort", 32'({TXD, BUSY, GRANT}), 32'h20);
    idle_chk(60, "no_done");
    DIN = 32'h3C00C300;
    REQ = 4'b1010;
    push(4'b0010, 8'hC3);
    check_frame(1'b1, 1'b0);
    DIN = 32'h00000007;
    REQ = 4'b0001;
    push(4'b0001, 8'h07);
    check_frame(1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
